// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - Memory-mapped edge-triggered interrupt controller with fixed priority and CAUSE/EOI handshake.
module irq_controller #(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             kernel_mode,
    input  logic             irq_take,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             mem_wr,
    input  logic             mem_rd,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam logic [1:0] OFF_PEND  = 2'd0;
    localparam logic [1:0] OFF_MASK  = 2'd1;
    localparam logic [1:0] OFF_CAUSE = 2'd2;
    localparam logic [1:0] OFF_EOI   = 2'd3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   src_q, src_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [3:0]         cause_idx_q, cause_idx_d;

    logic [31:0]        offset;
    logic               sel;
    logic [1:0]         reg_idx;
    logic               wr_pend, wr_mask, wr_eoi;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   masked;
    logic               in_service;
    logic               take;
    logic [3:0]         win;
    logic               unused_wdata;

    // Subtracting the base keeps decode correct for any word-aligned base.
    assign offset  = addr - BASE_ADDR;
    assign sel     = (offset[31:4] == 28'd0) && (offset[1:0] == 2'b00);
    assign reg_idx = offset[3:2];

    assign wr_pend = mem_wr && sel && (reg_idx == OFF_PEND);
    assign wr_mask = mem_wr && sel && (reg_idx == OFF_MASK);
    assign wr_eoi  = mem_wr && sel && (reg_idx == OFF_EOI);

    assign unused_wdata = ^wdata;

    assign rise       = src & ~src_q;
    assign masked     = pending_q & mask_q;
    assign in_service = (state_q == ST_SERVICE);
    assign irq        = ~in_service & ~kernel_mode & (|masked);
    assign take       = irq_take & irq;

    always_comb begin
        win = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win = 4'(i);
            end
        end
    end

    // A new edge always wins so that no event is lost to a concurrent clear.
    always_comb begin
        src_d = src;
        for (int i = 0; i < N_SRC; i++) begin
            if (rise[i]) begin
                pending_d[i] = 1'b1;
            end else if (wr_pend && wdata[i]) begin
                pending_d[i] = 1'b0;
            end else if (take && (win == 4'(i))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
        mask_d      = wr_mask ? wdata[N_SRC-1:0] : mask_q;
        cause_idx_d = take ? win : cause_idx_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (take)   state_d = ST_SERVICE;
            ST_SERVICE: if (wr_eoi) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        if (mem_rd && sel) begin
            case (reg_idx)
                OFF_PEND:  rdata = 32'(pending_q);
                OFF_MASK:  rdata = 32'(mask_q);
                OFF_CAUSE: rdata = {in_service, 27'd0, cause_idx_q};
                default:   rdata = 32'h0;
            endcase
        end
    end

    // Edge history resets high so lines already asserted do not fire on release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            src_q       <= '1;
            pending_q   <= '0;
            mask_q      <= '0;
            cause_idx_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            cause_idx_q <= cause_idx_d;
        end
    end

endmodule
